// File: rtl/vx_dot8_gather_pkg.sv
// Shared width constants and gather FSM states for the dot8 result gather path.
package vx_dot8_gather_pkg;

   localparam int unsigned NUM_THREADS = 4;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned UUID_WIDTH  = 44;
   localparam int unsigned NUM_WARPS   = 4;
   localparam int unsigned NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned PC_BITS     = 32;
   localparam int unsigned NUM_REGS    = 32;
   localparam int unsigned NR_BITS     = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      StIdle,
      StCollect,
      StFull
   } gather_state_e;

endpackage

// File: rtl/vx_dot8_gather.sv
// Reassembles lane-serialized ALU result beats into one full-warp commit.
// Holds one complete warp; the sink's ready only throttles the source while full.
module vx_dot8_gather
   import vx_dot8_gather_pkg::*;
#(
   parameter string        INSTANCE_ID = "",
   parameter int unsigned  NUM_LANES   = 1,
   localparam int unsigned NUM_BEATS   = NUM_THREADS / NUM_LANES,
   localparam int unsigned PID_BITS    = $clog2(NUM_BEATS),
   localparam int unsigned PID_W       = (PID_BITS > 0) ? PID_BITS : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   // serialized beats
   input  logic                                result_valid,
   output logic                                result_ready,
   input  logic [UUID_WIDTH-1:0]               result_uuid,
   input  logic [NW_WIDTH-1:0]                 result_wid,
   input  logic [NUM_LANES-1:0]                result_tmask,
   input  logic [PC_BITS-1:0]                  result_pc,
   input  logic                                result_wb,
   input  logic [NR_BITS-1:0]                  result_rd,
   input  logic [PID_W-1:0]                    result_pid,
   input  logic                                result_sop,
   input  logic                                result_eop,
   input  logic [NUM_LANES-1:0][XLEN-1:0]      result_data,
   // full-warp commit
   output logic                                commit_valid,
   input  logic                                commit_ready,
   output logic [UUID_WIDTH-1:0]               commit_uuid,
   output logic [NW_WIDTH-1:0]                 commit_wid,
   output logic [NUM_THREADS-1:0]              commit_tmask,
   output logic [PC_BITS-1:0]                  commit_pc,
   output logic                                commit_wb,
   output logic [NR_BITS-1:0]                  commit_rd,
   output logic                                commit_pid,
   output logic                                commit_sop,
   output logic                                commit_eop,
   output logic [NUM_THREADS-1:0][XLEN-1:0]    commit_data,
   output logic                                err_seq
);

   gather_state_e state_q, state_d, base_state;
   logic          valid_q;
   logic          err_q, err_d;
   logic [NUM_THREADS-1:0] tmask_q, tmask_d;
   logic [NUM_THREADS-1:0] lane_sel;
   logic          beat_fire, commit_fire, restart, accept;

   logic [NUM_THREADS-1:0][XLEN-1:0] data_q;
   logic [UUID_WIDTH-1:0]            uuid_q;
   logic [NW_WIDTH-1:0]              wid_q;
   logic [PC_BITS-1:0]               pc_q;
   logic                             wb_q;
   logic [NR_BITS-1:0]               rd_q;

   assign result_ready = (state_q != StFull) || commit_ready;
   assign beat_fire    = result_valid && result_ready;
   assign commit_fire  = valid_q && commit_ready;

   always_comb begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         lane_sel[t] = (PID_BITS == 0) || (result_pid == PID_W'(t / NUM_LANES));
      end
   end

   always_comb begin
      // a beat arriving while the full warp drains is treated as if from idle
      base_state = (state_q == StFull && commit_fire) ? StIdle : state_q;
      restart    = beat_fire && result_sop;
      accept     = restart || (beat_fire && base_state == StCollect);

      err_d = err_q;
      if (beat_fire) begin
         if (base_state == StIdle && !result_sop) begin
            err_d = 1'b1;
         end
         if (base_state == StCollect && (result_sop || result_wid != wid_q)) begin
            err_d = 1'b1;
         end
      end

      state_d = state_q;
      if (accept) begin
         state_d = result_eop ? StFull : StCollect;
      end else if (commit_fire) begin
         state_d = StIdle;
      end

      tmask_d = tmask_q;
      if (accept) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (lane_sel[t]) begin
               tmask_d[t] = result_tmask[t % NUM_LANES];
            end else if (restart) begin
               tmask_d[t] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         tmask_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == StFull);
         err_q   <= err_d;
         tmask_q <= tmask_d;
      end
   end

   // payload bank is unreset; it is only meaningful while commit_valid is high
   always_ff @(posedge clk) begin
      if (restart) begin
         uuid_q <= result_uuid;
         wid_q  <= result_wid;
         pc_q   <= result_pc;
         wb_q   <= result_wb;
         rd_q   <= result_rd;
      end
      if (accept) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (lane_sel[t]) begin
               data_q[t] <= result_data[t % NUM_LANES];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && beat_fire) begin
         assert (int'(result_pid) < int'(NUM_BEATS))
            else $error("%s: beat pid out of range", INSTANCE_ID);
      end
   end

   assign commit_valid = valid_q;
   assign commit_uuid  = uuid_q;
   assign commit_wid   = wid_q;
   assign commit_tmask = tmask_q;
   assign commit_pc    = pc_q;
   assign commit_wb    = wb_q;
   assign commit_rd    = rd_q;
   assign commit_pid   = 1'b0;
   assign commit_sop   = 1'b1;
   assign commit_eop   = 1'b1;
   assign commit_data  = data_q;
   assign err_seq      = err_q;

endmodule
